// File: rtl/stage_mem_hs.sv
// Memory pipeline stage with a request/grant/response data-memory handshake.
// Optional misaligned/illegal-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module stage_mem_hs #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_flush,
  input  logic                mem_valid,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          mem_funct3,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     alu_out,
  input  logic                jump,
  input  logic [XLEN-1:0]     pc,
  output logic                mem_ready,
  output logic [XLEN-1:0]     result,
  output logic [XLEN-1:0]     readdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                misalign_trap,
`endif
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_wstrb,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic                kill_reg, kill_next;
  logic [XLEN-1:0]     rdata_reg;
  logic                req_we_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [NB-1:0]       req_wstrb_reg;
  logic [XLEN-1:0]     req_wdata_reg;
  logic [2:0]          req_funct3_reg;
  logic [OFF_W-1:0]    req_off_reg;

  logic                mem_op;
  logic                illegal_f3;
  logic [2:0]          eff_funct3;
  logic [OFF_W-1:0]    raw_off;
  logic [OFF_W-1:0]    size_mask;
  logic [OFF_W-1:0]    in_off;
  logic [ADDR_W-1:0]   in_addr;
  logic [NB-1:0]       in_wstrb;
  logic [XLEN-1:0]     in_wdata;
  logic                trap_cond;
  logic                load_req;
  logic                capture;
  logic [XLEN-1:0]     lane;

  assign mem_op = mem_valid & (mem_read | mem_write);
  assign result = jump ? (pc + XLEN'(4)) : alu_out;

  // On a 32-bit datapath LD/SD/LWU do not exist; they degrade to LW/SW.
  assign illegal_f3 = (XLEN == 32) &&
                      ((mem_funct3[1:0] == 2'b11) || (mem_funct3 == 3'b110));
  assign eff_funct3 = illegal_f3 ? 3'b010 : mem_funct3;

  always_comb begin
    case (eff_funct3[1:0])
      2'b00:   size_mask = '0;
      2'b01:   size_mask = OFF_W'(1);
      2'b10:   size_mask = OFF_W'(3);
      default: size_mask = OFF_W'(7);
    endcase
  end

  assign raw_off = mem_addr[OFF_W-1:0];
  assign in_off  = raw_off & ~size_mask;
  assign in_addr = {mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Per-lane strobe and replicated store data.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [OFF_W-1:0] LANE = OFF_W'(gi);
    assign in_wstrb[gi] = mem_write & ((LANE & ~size_mask) == in_off);
    assign in_wdata[8*gi +: 8] =
      (eff_funct3[1:0] == 2'b00) ? mem_wdata[7:0] :
      (eff_funct3[1:0] == 2'b01) ? mem_wdata[8*(gi%2) +: 8] :
      (eff_funct3[1:0] == 2'b10) ? mem_wdata[8*(gi%4) +: 8] :
                                   mem_wdata[8*gi +: 8];
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned    = |(raw_off & size_mask);
  assign trap_cond     = misaligned | illegal_f3;
  assign misalign_trap = (state_reg == IDLE) & mem_op & ~mem_flush & trap_cond;
`else
  assign trap_cond = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    mem_ready  = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wstrb  = '0;
    bus_wdata  = '0;
    load_req   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        kill_next = 1'b0;
        if (mem_op && !mem_flush && !trap_cond) begin
          bus_req    = 1'b1;
          bus_we     = mem_write;
          bus_addr   = in_addr;
          bus_wstrb  = in_wstrb;
          bus_wdata  = in_wdata;
          load_req   = 1'b1;
          state_next = bus_gnt ? WAIT : REQ;
        end else begin
          mem_ready = 1'b1;
        end
      end
      REQ: begin
        // Request stays up until granted even if the instruction is killed.
        bus_req   = 1'b1;
        bus_we    = req_we_reg;
        bus_addr  = req_addr_reg;
        bus_wstrb = req_wstrb_reg;
        bus_wdata = req_wdata_reg;
        if (mem_flush) kill_next = 1'b1;
        if (bus_gnt)   state_next = WAIT;
      end
      WAIT: begin
        if (mem_flush) kill_next = 1'b1;
        if (bus_rvalid) begin
          capture    = 1'b1;
          kill_next  = 1'b0;
          state_next = (kill_reg | mem_flush) ? IDLE : DONE;
        end
      end
      DONE: begin
        mem_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wstrb = '0;
      bus_wdata = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      kill_reg       <= 1'b0;
      rdata_reg      <= '0;
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_wstrb_reg  <= '0;
      req_wdata_reg  <= '0;
      req_funct3_reg <= '0;
      req_off_reg    <= '0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
      if (load_req) begin
        req_we_reg     <= mem_write;
        req_addr_reg   <= in_addr;
        req_wstrb_reg  <= in_wstrb;
        req_wdata_reg  <= in_wdata;
        req_funct3_reg <= eff_funct3;
        req_off_reg    <= in_off;
      end
      if (capture) rdata_reg <= bus_rdata;
    end
  end

  assign lane = rdata_reg >> {req_off_reg, 3'b000};

  always_comb begin
    case (req_funct3_reg)
      3'b000:  readdata = XLEN'(signed'(lane[7:0]));
      3'b100:  readdata = XLEN'(lane[7:0]);
      3'b001:  readdata = XLEN'(signed'(lane[15:0]));
      3'b101:  readdata = XLEN'(lane[15:0]);
      3'b010:  readdata = XLEN'(signed'(lane[31:0]));
      3'b110:  readdata = XLEN'(lane[31:0]);
      default: readdata = lane;
    endcase
  end

endmodule

// File: tb/tb_stage_mem_hs.sv
// Self-checking bench for stage_mem_hs (XLEN=64): vector table, corner sequences,
// and randomized ops checked against a byte-level reference model.
module tb_stage_mem_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush, mem_valid, mem_read, mem_write, jump;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_addr, mem_wdata, alu_out, pc;
  logic        mem_ready;
  logic [63:0] result, readdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [63:0] bus_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stage_mem_hs #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .mem_flush(mem_flush), .mem_valid(mem_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_out(alu_out),
    .jump(jump), .pc(pc), .mem_ready(mem_ready), .result(result),
    .readdata(readdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gnt_dly;
    int          rsp_dly;
    logic [63:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    mem_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_flush  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    jump       = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  // Reference: natural-alignment forcing, lane strobes, replication, extension.
  function automatic void model(input logic wr, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata,
                                output logic [63:0] e_addr, output logic [7:0] e_strb,
                                output logic [63:0] e_wdata, output logic [63:0] e_rdata);
    int nbytes;
    int off;
    logic [63:0] val;
    nbytes = 1 << f3[1:0];
    off    = (int'(addr % 64'd8) / nbytes) * nbytes;
    e_addr = addr - (addr % 64'd8);
    e_strb = '0;
    for (int i = 0; i < 8; i++) begin
      if (wr && i >= off && i < off + nbytes) e_strb[i] = 1'b1;
      e_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    val = rdata >> (8 * off);
    if (nbytes < 8) begin
      val = val % (64'd1 << (8 * nbytes));
      if (!f3[2] && val[8*nbytes-1]) val = val - (64'd1 << (8 * nbytes));
    end
    e_rdata = val;
  endfunction

  task automatic run_mem(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int gnt_dly, input int rsp_dly,
                         input int flush_at, input logic next_mem,
                         input logic [63:0] e_addr, input logic [7:0] e_strb,
                         input logic [63:0] e_wdata, input logic [63:0] e_rdata);
    int rsp_c;
    int last;
    bit killed;
    rsp_c  = gnt_dly + rsp_dly;
    killed = (flush_at >= 1) && (flush_at <= rsp_c);
    last   = killed ? rsp_c : rsp_c + 1;
    mem_valid  = 1'b1;
    mem_read   = !wr;
    mem_write  = wr;
    mem_funct3 = f3;
    mem_addr   = addr;
    mem_wdata  = wdata;
    jump       = 1'b0;
    alu_out    = {$urandom, $urandom};
    for (int c = 0; c <= last; c++) begin
      mem_flush = (c == flush_at);
      if (killed && c > flush_at) begin
        // the slot now holds a younger instruction that must wait for the drain
        mem_read   = next_mem;
        mem_write  = 1'b0;
        mem_funct3 = 3'b011;
        mem_addr   = 64'h9990;
      end
      bus_gnt    = (c == gnt_dly);
      bus_rvalid = (c == rsp_c);
      bus_rdata  = (c == rsp_c) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      check({tag, " bus_req"}, 64'(bus_req), 64'(c <= gnt_dly));
      if (c <= gnt_dly) begin
        check({tag, " bus_addr"}, bus_addr, e_addr);
        check({tag, " bus_we"}, 64'(bus_we), 64'(wr));
        if (wr) begin
          check({tag, " bus_wstrb"}, 64'(bus_wstrb), 64'(e_strb));
          check({tag, " bus_wdata"}, bus_wdata, e_wdata);
        end
      end
      check({tag, " mem_ready"}, 64'(mem_ready), 64'(!killed && c == last));
      if (!killed && c == last && !wr) check({tag, " readdata"}, readdata, e_rdata);
      @(posedge clk);
      #1;
    end
    set_idle();
    $display("txn %s wr=%0b f3=%0d addr=0x%h gnt=%0d rsp=%0d flush_at=%0d",
             tag, wr, f3, addr, gnt_dly, rsp_dly, flush_at);
  endtask

  task automatic alu_op(input string tag, input logic j, input logic [63:0] p,
                        input logic [63:0] a);
    mem_valid = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_flush = 1'b0;
    jump      = j;
    pc        = p;
    alu_out   = a;
    @(negedge clk);
    check({tag, " result"}, result, j ? p + 64'd4 : a);
    check({tag, " mem_ready"}, 64'(mem_ready), 64'd1);
    check({tag, " bus_req"}, 64'(bus_req), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    $display("txn %s jump=%0b pc=0x%h alu=0x%h", tag, j, p, a);
  endtask

  initial begin
    logic [63:0] ea, ew, er, ra, wd, rd;
    logic [7:0]  es;
    logic        wr;
    logic [2:0]  f3;
    int          g, r, fa;

    vecs[0] = '{1'b0, 3'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 2,
                64'h1000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{1'b1, 3'd1, 64'h2006, 64'h1234, 64'h0, 3, 1,
                64'h2000, 8'hC0, 64'h1234_1234_1234_1234, 64'h0};
    vecs[2] = '{1'b0, 3'd6, 64'h4, 64'h0, 64'hDEAD_BEEF_0000_0000, 0, 1,
                64'h0, 8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF};
    vecs[3] = '{1'b0, 3'd3, 64'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2,
                64'h18, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 3'd1, 64'h102, 64'h0, 64'h0000_0000_8001_0000, 2, 1,
                64'h100, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
    vecs[5] = '{1'b1, 3'd0, 64'h305, 64'hAB, 64'h0, 0, 1,
                64'h300, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0};
    vecs[6] = '{1'b1, 3'd2, 64'h404, 64'hCAFE_F00D, 64'h0, 1, 3,
                64'h400, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'h0};
    vecs[7] = '{1'b1, 3'd3, 64'h508, 64'h1122_3344_5566_7788, 64'h0, 0, 2,
                64'h508, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
    vecs[8] = '{1'b0, 3'd4, 64'h7, 64'h0, 64'h9000_0000_0000_0000, 2, 2,
                64'h0, 8'h00, 64'h0, 64'h0000_0000_0000_0090};
    vecs[9] = '{1'b0, 3'd5, 64'hE, 64'h0, 64'hFFEE_0000_0000_0000, 0, 1,
                64'h8, 8'h00, 64'h0, 64'h0000_0000_0000_FFEE};

    // Reset with a load presented: nothing may reach the bus.
    set_idle();
    pc      = '0;
    alu_out = '0;
    rst     = 1'b1;
    mem_valid = 1'b1;
    mem_read  = 1'b1;
    mem_addr  = 64'h40;
    @(negedge clk);
    check("reset bus_req", 64'(bus_req), 64'd0);
    check("reset bus_wstrb", 64'(bus_wstrb), 64'd0);
    check("reset bus_addr", bus_addr, 64'd0);
    check("reset readdata", readdata, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    @(posedge clk);
    #1;

    alu_op("jump", 1'b1, 64'h8000_0000, 64'h1111);
    alu_op("alu", 1'b0, 64'h100, 64'hFEED_0000_1234_5678);

    for (int i = 0; i < 10; i++) begin
      run_mem($sformatf("vec%0d", i), vecs[i].wr, vecs[i].f3, vecs[i].addr,
              vecs[i].wdata, vecs[i].rdata, vecs[i].gnt_dly, vecs[i].rsp_dly, -1, 1'b0,
              vecs[i].e_addr, vecs[i].e_strb, vecs[i].e_wdata, vecs[i].e_rdata);
    end

    // LW killed during WAIT; the response is discarded and the ALU op follows.
    run_mem("lw_flush_wait", 1'b0, 3'b010, 64'h10, 64'h0, 64'h1234_5678, 0, 3, 2, 1'b0,
            64'h10, 8'h00, 64'h0, 64'h0);
    alu_op("after_flush", 1'b0, 64'h0, 64'h77);

    // Store killed while still waiting for grant; a new load waits behind the drain.
    run_mem("sw_flush_req", 1'b1, 3'b010, 64'h620, 64'h5555_AAAA, 64'h0, 3, 2, 1, 1'b1,
            64'h620, 8'h0F, 64'h5555_AAAA_5555_AAAA, 64'h0);
    alu_op("after_flush2", 1'b1, 64'h40, 64'h0);

    // Flush in IDLE suppresses the request entirely.
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    mem_funct3 = 3'b011;
    mem_addr   = 64'h700;
    mem_flush  = 1'b1;
    @(negedge clk);
    check("idle_flush bus_req", 64'(bus_req), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    alu_op("after_idle_flush", 1'b0, 64'h0, 64'h99);

    // Reset mid-transaction drops bus_req at once.
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    mem_funct3 = 3'b010;
    mem_addr   = 64'h840;
    @(negedge clk);
    check("midrst req0", 64'(bus_req), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst req1", 64'(bus_req), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst dropped", 64'(bus_req), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    alu_op("after_midrst", 1'b0, 64'h0, 64'h55);

`ifdef MEM_MISALIGN_TRAP_EN
    mem_valid  = 1'b1;
    mem_read   = 1'b1;
    mem_funct3 = 3'b010;
    mem_addr   = 64'h2;
    @(negedge clk);
    check("trap misalign_trap", 64'(misalign_trap), 64'd1);
    check("trap mem_ready", 64'(mem_ready), 64'd1);
    check("trap bus_req", 64'(bus_req), 64'd0);
    mem_flush = 1'b1;
    #1;
    check("trap flushed", 64'(misalign_trap), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    $display("txn trap LW addr=0x2");
`else
    run_mem("lw_misalign", 1'b0, 3'b010, 64'h2, 64'h0, 64'h0000_0000_FFFF_FFFE, 0, 1, -1,
            1'b0, 64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mem("sw_misalign", 1'b1, 3'b010, 64'h1006, 64'h5566_7788, 64'h0, 1, 1, -1, 1'b0,
            64'h1000, 8'hF0, 64'h5566_7788_5566_7788, 64'h0);
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        alu_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        wr = 1'($urandom_range(0, 1));
        f3 = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
        ra = {$urandom, $urandom};
`ifdef MEM_MISALIGN_TRAP_EN
        ra = ra & ~((64'd1 << f3[1:0]) - 64'd1);
`endif
        wd = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        g  = $urandom_range(0, 3);
        r  = $urandom_range(1, 3);
        fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, g + r) : -1;
        model(wr, f3, ra, wd, rd, ea, es, ew, er);
        run_mem($sformatf("rnd%0d", n), wr, f3, ra, wd, rd, g, r, fa,
                1'($urandom_range(0, 1)), ea, es, ew, er);
        if (fa >= 0) alu_op($sformatf("rnd%0d_post", n), 1'b0, 64'h0, {$urandom, $urandom});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
